// File: rtl/mul_share_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_sched_pkg
// Description : Shared types and constants for the shared-multiplier
//               scheduler: operand-pair struct, FSM state enum, widths.
// Revision    : 1.0  initial release
// ============================================================================
package mul_share_sched_pkg;

    localparam int OP_W   = 9;    // width of one signed operand
    localparam int PROD_W = 18;   // width of the full-precision product
    localparam int CNT_W  = 16;   // width of the completed-operation counter

    // Packed operand pair as presented on reqN_ops: [17:9]=sel0, [8:0]=sel1.
    typedef struct packed {
        logic signed [OP_W-1:0] sel0;
        logic signed [OP_W-1:0] sel1;
    } product0_t;

    // Scheduler states: waiting for a request, multiplying, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Flatten an operand pair into its bus representation.
    function automatic logic [2*OP_W-1:0] product0_to_lv(input product0_t p);
        return p;
    endfunction

    // Interpret a bus value as an operand pair.
    function automatic product0_t product0_from_lv(input logic [2*OP_W-1:0] v);
        return product0_t'(v);
    endfunction

endpackage : mul_share_sched_pkg
`default_nettype wire

// File: rtl/mul_share_sched_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe
// Description : Fixed-latency 9x9 signed multiplier. The product appears on
//               p_o exactly MUL_LAT clocks after the operands are presented;
//               there is no handshake, the caller tracks the latency.
// Revision    : 1.0  initial release
// ============================================================================
module mul_pipe
    import mul_share_sched_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic signed [OP_W-1:0]   a_i,
    input  logic signed [OP_W-1:0]   b_i,
    output logic signed [PROD_W-1:0] p_o
);

    logic signed [PROD_W-1:0] a_ext_w;
    logic signed [PROD_W-1:0] b_ext_w;
    logic signed [PROD_W-1:0] prod_w;
    logic signed [PROD_W-1:0] stage_q [MUL_LAT];

    // Sign-extend to product width first; a 9x9 signed product always fits
    // in 18 bits, so the truncated 18x18 result is exact.
    assign a_ext_w = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};
    assign b_ext_w = {{(PROD_W-OP_W){b_i[OP_W-1]}}, b_i};
    assign prod_w  = a_ext_w * b_ext_w;

    // Product register followed by MUL_LAT-1 plain delay stages.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= prod_w;
            for (int i = 1; i < MUL_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign p_o = stage_q[MUL_LAT-1];

endmodule : mul_pipe
`default_nettype wire

// File: rtl/mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_sched
// Description : Shares one pipelined signed multiplier between two requesters
//               with round-robin arbitration. One operation is in flight at a
//               time; the result is held until the consumer accepts it.
// Revision    : 1.0  initial release
// ============================================================================
module mul_share_sched
    import mul_share_sched_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    input  logic                req0_valid,
    input  logic [2*OP_W-1:0]   req0_ops,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [2*OP_W-1:0]   req1_ops,
    output logic                req1_ready,
    output logic                rsp_valid,
    output logic [PROD_W-1:0]   rsp_data,
    output logic                rsp_id,
    input  logic                rsp_ready,
    output logic [CNT_W-1:0]    ops_done
);

    // Counter is loaded with MUL_LAT-1 so MUL lasts exactly MUL_LAT cycles.
    localparam logic [2:0] LAT_LOAD = 3'(MUL_LAT - 1);

    state_t             state_q,    state_d;
    logic [2:0]         cnt_q,      cnt_d;
    logic               last_id_q,  last_id_d;
    logic               id_q,       id_d;
    product0_t          ops_q,      ops_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    logic               any_valid_w;
    logic               win_w;
    logic               accept_w;
    logic signed [PROD_W-1:0] prod_w;

    // Round-robin pick: a lone requester wins, a tie goes to the one that
    // did not win last time. Grants only in IDLE and never during reset.
    always_comb begin
        any_valid_w = req0_valid | req1_valid;
        win_w       = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;
        accept_w    = (state_q == IDLE) & system1000_rstn & any_valid_w;
    end

    assign req0_ready = accept_w & ~win_w;
    assign req1_ready = accept_w &  win_w;

    // Next-state logic: capture on accept, count down the multiplier latency,
    // then hold the result until the consumer takes it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_id_d  = last_id_q;
        id_d       = id_q;
        ops_d      = ops_q;
        ops_done_d = ops_done_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    state_d   = MUL;
                    cnt_d     = LAT_LOAD;
                    last_id_d = win_w;
                    id_d      = win_w;
                    ops_d     = product0_from_lv(win_w ? req1_ops : req0_ops);
                end
            end
            MUL: begin
                if (cnt_q == 3'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    ops_done_d = ops_done_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_id_q  <= 1'b1;
            id_q       <= 1'b0;
            ops_q      <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_id_q  <= last_id_d;
            id_q       <= id_d;
            ops_q      <= ops_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Operands stay registered for the whole operation, so the pipeline
    // output is stable throughout HOLD.
    mul_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk_i  (system1000),
        .rstn_i (system1000_rstn),
        .a_i    (ops_q.sel0),
        .b_i    (ops_q.sel1),
        .p_o    (prod_w)
    );

    assign rsp_valid = (state_q == HOLD);
    assign rsp_data  = (state_q == HOLD) ? prod_w : '0;
    assign rsp_id    = (state_q == HOLD) ? id_q   : 1'b0;
    assign ops_done  = ops_done_q;

endmodule : mul_share_sched
`default_nettype wire

// File: tb/tb_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_sched
// Description : Self-checking bench for mul_share_sched. A cycle-based
//               reference model (pending flag, accept cycle, product computed
//               with integer arithmetic) predicts every output each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_sched;

    localparam int ML = 2;

    logic        system1000 = 1'b0;
    logic        system1000_rstn;
    logic        req0_valid, req1_valid;
    logic [17:0] req0_ops, req1_ops;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic [17:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic [15:0] ops_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pend = 0;
    int          m_acc  = 0;
    logic [17:0] m_prod = '0;
    bit          m_id   = 0;
    bit          m_last = 1;
    logic [15:0] m_ops  = '0;
    int          cyc    = 0;

    // Observed values of the most recent step
    bit          o_rv, o_rid;
    logic [17:0] o_rd;
    logic [15:0] o_od;
    int          grant_q[$];
    int          gcyc_q[$];

    always #5 system1000 = ~system1000;

    mul_share_sched #(.MUL_LAT(ML)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req0_valid      (req0_valid),
        .req0_ops        (req0_ops),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_ops        (req1_ops),
        .req1_ready      (req1_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_id          (rsp_id),
        .rsp_ready       (rsp_ready),
        .ops_done        (ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] mk(input int a, input int b);
        return {a[8:0], b[8:0]};
    endfunction

    // One clock cycle: drive inputs, compare all outputs with the model,
    // then advance the model by the rules of this cycle.
    task automatic step(input bit v0, input logic [17:0] o0, input bit v1,
                        input logic [17:0] o1, input bit rr, input bit rn);
        bit ev, acc, win;
        logic [17:0] ed, o;
        bit eid;
        logic signed [8:0] a, b;
        int p;
        @(negedge system1000);
        req0_valid = v0; req0_ops = o0;
        req1_valid = v1; req1_ops = o1;
        rsp_ready = rr;  system1000_rstn = rn;
        #1;
        ev  = m_pend && (cyc >= m_acc + ML + 1);
        acc = rn && !m_pend && (v0 || v1);
        if (v0 && v1) win = !m_last;
        else          win = v1;
        ed  = ev ? m_prod : 18'd0;
        eid = ev ? m_id : 1'b0;
        chk("req0_ready", req0_ready, acc && !win);
        chk("req1_ready", req1_ready, acc && win);
        chk("rsp_valid",  rsp_valid,  ev);
        chk("rsp_data",   rsp_data,   ed);
        chk("rsp_id",     rsp_id,     eid);
        chk("ops_done",   ops_done,   m_ops);
        o_rv = rsp_valid; o_rd = rsp_data; o_rid = rsp_id; o_od = ops_done;
        if (req0_ready) begin grant_q.push_back(0); gcyc_q.push_back(cyc); end
        if (req1_ready) begin grant_q.push_back(1); gcyc_q.push_back(cyc); end
        if (!rn) begin
            m_pend = 0; m_last = 1; m_ops = '0;
        end else if (acc) begin
            o = win ? o1 : o0;
            a = o[17:9]; b = o[8:0];
            p = a * b;
            m_prod = p[17:0];
            m_pend = 1; m_acc = cyc; m_id = win; m_last = win;
        end else if (ev && rr) begin
            m_pend = 0; m_ops = m_ops + 16'd1;
        end
        cyc++;
    endtask

    task automatic idle(input bit rr);
        step(0, '0, 0, '0, rr, 1);
    endtask

    // Issue one request from a single requester and check the response.
    task automatic run_one(input bit who, input logic [17:0] ops,
                           input logic [17:0] expd, input string tag);
        bit found = 0;
        if (who) step(0, '0, 1, ops, 1, 1);
        else     step(1, ops, 0, '0, 1, 1);
        for (int i = 0; i < 12 && !found; i++) begin
            idle(1);
            if (o_rv) begin
                found = 1;
                chk({tag, "_data"}, o_rd, expd);
                chk({tag, "_id"}, o_rid, who);
            end
        end
        chk({tag, "_seen"}, found, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_pend; i++) idle(1);
        idle(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [17:0] hd;
        bit hid;
        req0_valid = 0; req1_valid = 0; req0_ops = '0; req1_ops = '0;
        rsp_ready = 0; system1000_rstn = 0;
        repeat (2) @(posedge system1000);

        // Reset state, readies held low while in reset even with requests
        step(1, mk(1, 1), 1, mk(2, 2), 1, 0);
        step(0, '0, 0, '0, 0, 0);

        // Single requester, (3,-5): response at t+3, -15, id 0, count 1
        t = cyc;
        step(1, mk(3, -5), 0, '0, 0, 1);
        chk("acc_t", grant_q.size(), 1);
        idle(0); chk("t1_valid", o_rv, 0);
        idle(0); chk("t2_valid", o_rv, 0);
        idle(1);
        chk("t3_valid", o_rv, 1);
        chk("t3_data", o_rd, 18'h3FFF1);
        chk("t3_id", o_rid, 0);
        chk("t3_cyc", cyc - 1 - t, 3);
        idle(0); chk("t4_count", o_od, 1);

        // Continuous tie with rsp_ready high: 0,1,0,1 every 4 cycles
        step(0, '0, 0, '0, 0, 0);
        grant_q.delete(); gcyc_q.delete();
        for (int i = 0; i < 16; i++) step(1, mk(i, 7), 1, mk(-i, 3), 1, 1);
        chk("rr_n", grant_q.size(), 4);
        if (grant_q.size() >= 4) begin
            chk("rr_g0", grant_q[0], 0);
            chk("rr_g1", grant_q[1], 1);
            chk("rr_g2", grant_q[2], 0);
            chk("rr_g3", grant_q[3], 1);
            chk("rr_gap", gcyc_q[3] - gcyc_q[2], 4);
        end
        drain();

        // Operand extremes
        run_one(1, mk(-256, -256), 18'h10000, "ext_nn");
        run_one(0, mk(-256, 255),  18'h30100, "ext_np");
        run_one(1, mk(0, -123),    18'h00000, "zero");
        drain();

        // Back-pressure: result held 5 cycles with rsp_ready low
        step(1, mk(-7, 9), 0, '0, 0, 1);
        for (int i = 0; i < 12 && !o_rv; i++) idle(0);
        hd = o_rd; hid = o_rid;
        chk("hold_val", hd, mk(-7, 9) == '0 ? 18'h0 : 18'h3FFC1);
        for (int i = 0; i < 5; i++) begin
            step(1, mk(5, 5), 1, mk(6, 6), 0, 1);
            chk("hold_data", o_rd, hd);
            chk("hold_id", o_rid, hid);
        end
        idle(1);
        drain();

        // Reset during MUL aborts; next tie goes to requester 0
        step(0, '0, 1, mk(11, 11), 0, 1);
        idle(1);
        step(0, '0, 0, '0, 1, 0);
        idle(1);
        chk("abort_valid", o_rv, 0);
        chk("abort_count", o_od, 0);
        grant_q.delete();
        step(1, mk(2, 2), 1, mk(4, 4), 1, 1);
        chk("abort_tie", grant_q.size() == 1 ? grant_q[0] : 9, 0);
        for (int i = 0; i < 6; i++) idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), 18'($urandom), $urandom_range(0, 1),
                 18'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) != 0);
        end
        drain();

        // Counter wrap: preload near the top, complete two operations
        force dut.ops_done_q = 16'hFFFE;
        @(posedge system1000);
        #1;
        release dut.ops_done_q;
        m_ops = 16'hFFFE;
        idle(0); chk("wrap_pre", o_od, 16'hFFFE);
        run_one(0, mk(1, 1), 18'h1, "wrap_a");
        run_one(1, mk(2, 3), 18'h6, "wrap_b");
        idle(0); chk("wrap_zero", o_od, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mul_share_sched
`default_nettype wire
